fb_scanout: RTL
===============

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter H_RES, default 640, visible pixels per line.
REQ-002 Parameter V_RES, default 480, visible lines per frame.
REQ-003 CLK  input  1  system clock (100 MHz); all state on rising edge.
REQ-004 RST_BTN  input  1  reset, asynchronous, active-low.
REQ-005 i_pix_stb  input  1  one-CLK pixel strobe; at least 2 CLK between strobes.
REQ-006 i_x  input  10  current pixel column from timing generator.
REQ-007 i_y  input  9  current pixel row from timing generator.
REQ-008 i_hs, i_vs  input  1 each  sync from timing generator, aligned with i_x/i_y.
REQ-009 o_rd_en  output  1  framebuffer read strobe.
REQ-010 o_rd_addr  output  20  {bank, i_y*H_RES+i_x} (bank = bit 19).
REQ-011 i_rd_data  input  6  {R[1:0],G[1:0],B[1:0]}, valid exactly 1 CLK after o_rd_en.
REQ-012 i_swap_req  input  1  single-CLK pulse from writer: back buffer complete.
REQ-013 o_swap_ack  output  1  single-CLK pulse: bank swap performed.
REQ-014 o_disp_bank  output  1  bank currently scanned out.
REQ-015 VGA_R, VGA_G, VGA_B  output  4 each  pixel colour.
REQ-016 VGA_HS_O, VGA_VS_O  output  1 each  delayed sync.

Function
REQ-017 On each i_pix_stb: latch i_x, i_y, i_hs, i_vs into stage A; o_rd_en=1 for that CLK iff i_x<H_RES and i_y<V_RES; else o_rd_en=0.
REQ-018 o_rd_addr valid only while o_rd_en=1; multiply-add in 20-bit unsigned arithmetic, no truncation.
REQ-019 CLK after o_rd_en: capture i_rd_data into data register; otherwise data register holds.
REQ-020 On next i_pix_stb: colour outputs = stage A visible ? each 2-bit field replicated to 4 bits ({c,c}) : 4'h0; VGA_HS_O/VGA_VS_O = stage A sync.
REQ-021 Total latency: outputs lag inputs by exactly one pixel strobe; outputs hold between strobes.
REQ-022 Swap FSM states IDLE, PENDING, ACK.
REQ-023 IDLE -> PENDING on i_swap_req=1.
REQ-024 PENDING -> ACK on the strobe with i_x==0 and i_y==V_RES (first blanking line); o_disp_bank toggles that CLK.
REQ-025 ACK: o_swap_ack=1 for exactly one CLK, then IDLE.
REQ-026 i_swap_req during PENDING ignored (coalesced into single swap).
REQ-027 i_swap_req during ACK -> next state PENDING, not IDLE.
REQ-028 Bank never changes during visible region; bank bit of o_rd_addr always equals o_disp_bank at issue time.

Reset
REQ-029 RST_BTN low asynchronously clears: colour outputs 0, VGA_HS_O=1, VGA_VS_O=1, o_rd_en=0, o_rd_addr=0, o_swap_ack=0, o_disp_bank=0, FSM=IDLE, stage A invalid.
REQ-030 Reset mid-PENDING discards the request; no ack issued after release.
REQ-031 First strobe after release outputs black (stage A invalid).

Configuration
REQ-032 Macro FB_SCANOUT_DOUBLE_BUFFER_EN defined: double buffering per REQ-022..028.
REQ-033 Macro undefined: o_disp_bank tied 0, address bit 19 tied 0, FSM absent, o_swap_ack = i_swap_req delayed one CLK.

Verification
REQ-034 Strobe x=5,y=2, i_rd_data=6'b11_01_00 -> o_rd_addr=1285 (bank 0), next strobe R=4'hF,G=4'h5,B=4'h0.
REQ-035 Strobe x=700,y=10 -> o_rd_en=0, next strobe RGB=0, sync delayed one strobe.
REQ-036 i_swap_req at x=100,y=50 -> no ack until strobe x=0,y=480; then o_disp_bank=1, o_swap_ack one-CLK pulse, next frame addresses have bit 19=1.
REQ-037 Two i_swap_req pulses in one frame -> single ack, single toggle.
REQ-038 RST_BTN low while PENDING -> all outputs at reset values immediately (no clock); after release, no ack at next frame boundary.
REQ-039 Build without FB_SCANOUT_DOUBLE_BUFFER_EN, pulse i_swap_req -> o_swap_ack next CLK, o_disp_bank stays 0.

Source files
------------

// File: rtl/fb_scanout.sv
// ============================================================================
// fb_scanout -- framebuffer scan-out: 2-bit-per-channel pixel fetch to VGA.
// Option: FB_SCANOUT_DOUBLE_BUFFER_EN enables bank swapping at frame boundary.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fb_scanout #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        i_pix_stb,
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_rd_en,
  output logic [19:0] o_rd_addr,
  input  logic [5:0]  i_rd_data,
  input  logic        i_swap_req,
  output logic        o_swap_ack,
  output logic        o_disp_bank,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS_O,
  output logic        VGA_VS_O
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);

  logic        visible;
  logic [19:0] lin_addr;
  logic        bank_bit;
  logic        a_valid, a_vis, a_hs, a_vs;
  logic        rd_pend;
  logic [5:0]  pix_data;
  logic [5:0]  cur_pix;

  assign visible  = ({1'b0, i_x} < H_LIM) && ({1'b0, i_y} < V_LIM);
  assign lin_addr = 20'(i_y) * 20'(H_RES) + 20'(i_x);
  // Read data may arrive on the same edge as the next strobe, so forward it.
  assign cur_pix  = rd_pend ? i_rd_data : pix_data;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
      rd_pend   <= 1'b0;
      pix_data  <= '0;
      a_valid   <= 1'b0;
      a_vis     <= 1'b0;
      a_hs      <= 1'b1;
      a_vs      <= 1'b1;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_HS_O  <= 1'b1;
      VGA_VS_O  <= 1'b1;
    end else begin
      rd_pend <= o_rd_en;
      if (rd_pend)
        pix_data <= i_rd_data;
      if (i_pix_stb) begin
        o_rd_en   <= visible;
        // lin_addr never exceeds 19 bits, so adding the bank places it in bit 19
        o_rd_addr <= visible ? (lin_addr + {bank_bit, 19'b0}) : '0;
        a_valid   <= 1'b1;
        a_vis     <= visible;
        a_hs      <= i_hs;
        a_vs      <= i_vs;
        VGA_R     <= (a_valid && a_vis) ? {2{cur_pix[5:4]}} : 4'h0;
        VGA_G     <= (a_valid && a_vis) ? {2{cur_pix[3:2]}} : 4'h0;
        VGA_B     <= (a_valid && a_vis) ? {2{cur_pix[1:0]}} : 4'h0;
        VGA_HS_O  <= a_hs;
        VGA_VS_O  <= a_vs;
      end else begin
        o_rd_en <= 1'b0;
      end
    end
  end

`ifdef FB_SCANOUT_DOUBLE_BUFFER_EN
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;

  logic [1:0] state, state_nxt;
  logic       disp_bank;
  logic       swap_point;

  // First strobe of the first blanking line: safe point to flip banks
  assign swap_point = i_pix_stb && (i_x == 10'd0) && ({1'b0, i_y} == V_LIM);

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_swap_req) state_nxt = S_PENDING;
      S_PENDING: if (swap_point) state_nxt = S_ACK;
      S_ACK:     state_nxt = i_swap_req ? S_PENDING : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_swap_ack = (state == S_ACK);
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN)
      disp_bank <= 1'b0;
    else if (state == S_PENDING && swap_point)
      disp_bank <= ~disp_bank;
  end

  assign o_disp_bank = disp_bank;
  assign bank_bit    = disp_bank;
`else
  logic swap_req_d;

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN)
      swap_req_d <= 1'b0;
    else
      swap_req_d <= i_swap_req;
  end

  assign o_swap_ack  = swap_req_d;
  assign o_disp_bank = 1'b0;
  assign bank_bit    = 1'b0;
`endif

endmodule

`default_nettype wire
